// File: rtl/csr_unit.sv
// Machine-mode CSR file: CSRRW/RS/RC execution, 64-bit cycle/instret counters,
// and the trap-entry / MRET updates that feed the fetch redirect logic.
module csr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MISA_VAL    = 32'h4000_1100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_valid,
  input  logic [1:0]  csr_op_type,
  input  logic        csr_use_imm,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  rs1_addr,
  input  logic [31:0] rs1_data,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        instret_inc,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret_valid,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_out,
  output logic        mie_global
);

  localparam logic [1:0] OpRw = 2'b00;
  localparam logic [1:0] OpRs = 2'b01;
  localparam logic [1:0] OpRc = 2'b10;

  logic        mstatus_mie_q, mstatus_mpie_q;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle_q, minstret_q;

  logic [31:0] old_val, src, new_val;
  logic        addr_ok, write_intent, illegal, we_any, we;

  always_comb begin
    old_val = 32'h0;
    addr_ok = 1'b1;
    case (csr_addr)
      12'h300: old_val = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
      12'h301: old_val = MISA_VAL;
      12'h304: old_val = mie_q;
      12'h305: old_val = mtvec_q;
      12'h340: old_val = mscratch_q;
      12'h341: old_val = mepc_q;
      12'h342: old_val = mcause_q;
      12'h343: old_val = mtval_q;
      12'h344: old_val = 32'h0;
      12'hB00, 12'hC00: old_val = mcycle_q[31:0];
      12'hB80, 12'hC80: old_val = mcycle_q[63:32];
      12'hB02, 12'hC02: old_val = minstret_q[31:0];
      12'hB82, 12'hC82: old_val = minstret_q[63:32];
      12'hF14: old_val = HART_ID;
      default: addr_ok = 1'b0;
    endcase
  end

  assign src          = csr_use_imm ? {27'b0, rs1_addr} : rs1_data;
  assign write_intent = (csr_op_type == OpRw) || (rs1_addr != 5'd0);
  assign illegal      = !addr_ok || (csr_op_type == 2'b11) ||
                        (write_intent && (csr_addr[11:10] == 2'b11));

  always_comb begin
    new_val = src;
    case (csr_op_type)
      OpRs:    new_val = old_val | src;
      OpRc:    new_val = old_val & ~src;
      default: new_val = src;
    endcase
  end

  assign csr_illegal = csr_valid && illegal;
  assign csr_rdata   = (csr_valid && !illegal) ? old_val : 32'h0;
  assign we_any      = csr_valid && !illegal && write_intent;
  // Counters ignore trap/MRET; all other state loses to them.
  assign we          = we_any && !trap_valid && !mret_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'h0;
      mtvec_q        <= {MTVEC_RESET[31:2], 2'b00};
      mscratch_q     <= 32'h0;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      mtval_q        <= 32'h0;
    end else if (trap_valid) begin
      mepc_q         <= {trap_pc[31:2], 2'b00};
      mcause_q       <= trap_cause;
      mtval_q        <= trap_tval;
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else if (mret_valid) begin
      mstatus_mie_q  <= mstatus_mpie_q;
      mstatus_mpie_q <= 1'b1;
    end else if (we) begin
      case (csr_addr)
        12'h300: begin
          mstatus_mie_q  <= new_val[3];
          mstatus_mpie_q <= new_val[7];
        end
        12'h304: mie_q      <= new_val;
        12'h305: mtvec_q    <= {new_val[31:2], 2'b00};
        12'h340: mscratch_q <= new_val;
        12'h341: mepc_q     <= {new_val[31:2], 2'b00};
        12'h342: mcause_q   <= new_val;
        12'h343: mtval_q    <= new_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      if (we_any && csr_addr == 12'hB00)      mcycle_q[31:0]  <= new_val;
      else if (we_any && csr_addr == 12'hB80) mcycle_q[63:32] <= new_val;
      else                                    mcycle_q        <= mcycle_q + 64'd1;

      if (we_any && csr_addr == 12'hB02)      minstret_q[31:0]  <= new_val;
      else if (we_any && csr_addr == 12'hB82) minstret_q[63:32] <= new_val;
      else if (instret_inc)                   minstret_q        <= minstret_q + 64'd1;
    end
  end

  assign trap_vector = mtvec_q;
  assign mepc_out    = mepc_q;
  assign mie_global  = mstatus_mie_q;

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: stimulus queues expected CSR responses,
// a negedge monitor pops and compares whenever csr_valid is presented.
module tb_csr_unit;

  localparam logic [31:0] MtvecRst = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_valid, csr_use_imm, instret_inc, trap_valid, mret_valid;
  logic [1:0]  csr_op_type;
  logic [11:0] csr_addr;
  logic [4:0]  rs1_addr;
  logic [31:0] rs1_data, trap_cause, trap_pc, trap_tval;
  logic [31:0] csr_rdata, trap_vector, mepc_out;
  logic        csr_illegal, mie_global;

  csr_unit #(
    .MTVEC_RESET(MtvecRst),
    .HART_ID    (32'd0),
    .MISA_VAL   (32'h4000_1100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .csr_valid  (csr_valid),
    .csr_op_type(csr_op_type),
    .csr_use_imm(csr_use_imm),
    .csr_addr   (csr_addr),
    .rs1_addr   (rs1_addr),
    .rs1_data   (rs1_data),
    .csr_rdata  (csr_rdata),
    .csr_illegal(csr_illegal),
    .instret_inc(instret_inc),
    .trap_valid (trap_valid),
    .trap_cause (trap_cause),
    .trap_pc    (trap_pc),
    .trap_tval  (trap_tval),
    .mret_valid (mret_valid),
    .trap_vector(trap_vector),
    .mepc_out   (mepc_out),
    .mie_global (mie_global)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          chk_rd;
    logic [31:0] rd;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  always @(negedge clk) begin
    if (csr_valid && !rst) begin
      if (exp_q.size() == 0) begin
        check("unexpected_csr_response", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_illegal"}, {31'b0, csr_illegal}, {31'b0, e.ill});
        if (e.chk_rd) check({e.name, "_rdata"}, csr_rdata, e.rd);
      end
    end
  end

  task automatic csr(string name, logic [1:0] op, logic imm, logic [11:0] addr,
                     logic [4:0] ra, logic [31:0] rd_in, bit chk_rd,
                     logic [31:0] exp_rd, logic exp_ill);
    exp_t e;
    e.name = name; e.chk_rd = chk_rd; e.rd = exp_rd; e.ill = exp_ill;
    exp_q.push_back(e);
    csr_valid = 1'b1; csr_op_type = op; csr_use_imm = imm;
    csr_addr = addr; rs1_addr = ra; rs1_data = rd_in;
    @(posedge clk); #1;
    csr_valid = 1'b0;
  endtask

  // Pure read: CSRRS with rs1=x0 carries no write intent.
  task automatic rd(string name, logic [11:0] addr, logic [31:0] exp_rd);
    csr(name, 2'b01, 1'b0, addr, 5'd0, 32'hFFFF_FFFF, 1'b1, exp_rd, 1'b0);
  endtask

  task automatic idle(int n);
    csr_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1; csr_valid = 1'b0; csr_op_type = 2'b00; csr_use_imm = 1'b0;
    csr_addr = 12'h0; rs1_addr = 5'd0; rs1_data = 32'h0; instret_inc = 1'b0;
    trap_valid = 1'b0; trap_cause = 32'h0; trap_pc = 32'h0; trap_tval = 32'h0;
    mret_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_trap_vector", trap_vector, MtvecRst);
    check("rst_mepc_out", mepc_out, 32'h0);
    check("rst_mie_global", {31'b0, mie_global}, 32'h0);
    rd("rst_mstatus", 12'h300, 32'h0000_1800);
    rd("rst_mtvec", 12'h305, MtvecRst);
    rd("rst_mhartid", 12'hF14, 32'h0);
    rd("rst_misa", 12'h301, 32'h4000_1100);

    csr("mscratch_rw", 2'b00, 1'b0, 12'h340, 5'd7, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0);
    csr("mscratch_rs_x0", 2'b01, 1'b0, 12'h340, 5'd0, 32'hFFFF_FFFF, 1'b1,
        32'hDEAD_BEEF, 1'b0);
    csr("mscratch_rci", 2'b10, 1'b1, 12'h340, 5'h0F, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    rd("mscratch_after_rci", 12'h340, 32'hDEAD_BEE0);

    csr("mtvec_rw", 2'b00, 1'b0, 12'h305, 5'd1, 32'h8000_0007, 1'b1, MtvecRst, 1'b0);
    rd("mtvec_masked", 12'h305, 32'h8000_0004);
    check("trap_vector_out", trap_vector, 32'h8000_0004);

    csr("mcycle_set", 2'b00, 1'b0, 12'hB00, 5'd1, 32'd100, 1'b0, 32'h0, 1'b0);
    csr("cycle_ro_write", 2'b00, 1'b0, 12'hC00, 5'd1, 32'h0, 1'b1, 32'h0, 1'b1);
    rd("mcycle_unaffected", 12'hB00, 32'd101);
    csr("unimpl_7c0", 2'b01, 1'b0, 12'h7C0, 5'd0, 32'h0, 1'b1, 32'h0, 1'b1);
    csr("mhartid_rs_write", 2'b01, 1'b0, 12'hF14, 5'd3, 32'h1, 1'b1, 32'h0, 1'b1);
    csr("reserved_op", 2'b11, 1'b0, 12'h340, 5'd0, 32'h0, 1'b1, 32'h0, 1'b1);
    rd("mscratch_after_illegal", 12'h340, 32'hDEAD_BEE0);

    csr("mstatus_rsi_mie", 2'b01, 1'b1, 12'h300, 5'd8, 32'h0, 1'b1, 32'h0000_1800, 1'b0);
    check("mie_global_set", {31'b0, mie_global}, 32'h1);
    trap_valid = 1'b1; trap_pc = 32'h100; trap_cause = 32'h0B; trap_tval = 32'h0;
    idle(1);
    trap_valid = 1'b0;
    check("trap_mepc_out", mepc_out, 32'h100);
    check("trap_mie_global", {31'b0, mie_global}, 32'h0);
    rd("trap_mepc", 12'h341, 32'h100);
    rd("trap_mcause", 12'h342, 32'h0B);
    rd("trap_mstatus", 12'h300, 32'h0000_1880);
    mret_valid = 1'b1;
    idle(1);
    mret_valid = 1'b0;
    rd("mret_mstatus", 12'h300, 32'h0000_1888);

    trap_valid = 1'b1; trap_pc = 32'h307; trap_cause = 32'h02; trap_tval = 32'h55;
    csr("mepc_rw_vs_trap", 2'b00, 1'b0, 12'h341, 5'd1, 32'h200, 1'b1, 32'h100, 1'b0);
    trap_valid = 1'b0;
    rd("trap_wins_mepc", 12'h341, 32'h304);
    rd("trap_wins_mtval", 12'h343, 32'h55);
    rd("trap2_mstatus", 12'h300, 32'h0000_1880);

    csr("mcycle_lo_ff", 2'b00, 1'b0, 12'hB00, 5'd1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
    csr("mcycleh_zero", 2'b00, 1'b0, 12'hB80, 5'd1, 32'h0, 1'b1, 32'h0, 1'b0);
    rd("mcycle_lo_held", 12'hB00, 32'hFFFF_FFFF);
    rd("mcycleh_carry", 12'hB80, 32'h1);
    rd("mcycle_lo_wrapped", 12'hB00, 32'h1);
    rd("cycleh_mirror", 12'hC80, 32'h1);

    rd("minstret_zero", 12'hB02, 32'h0);
    repeat (3) begin
      instret_inc = 1'b1; idle(1);
      instret_inc = 1'b0; idle(1);
    end
    rd("minstret_three", 12'hB02, 32'd3);
    rd("instret_mirror", 12'hC02, 32'd3);

    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    rd("rst2_mscratch", 12'h340, 32'h0);
    rd("rst2_mtvec", 12'h305, MtvecRst);
    check("rst2_mepc_out", mepc_out, 32'h0);

    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
Machine-mode CSR file and trap-state block. It is the consumer of the CSR and system-instruction control fields produced by the instruction decoder: is_csr, csr_op_type, csr_use_imm, csr_addr, and the rs1 field.
- Executes CSRRW/RS/RC and their immediate forms.
- Maintains the 64-bit cycle and instret counters.
- Performs the mstatus/mepc/mcause/mtval updates for trap entry and MRET.
- Supplies the trap vector and return PC to the fetch redirect logic.

Parameters:
MTVEC_RESET, 32'h0000_0000, reset value of mtvec (direct mode, bits[1:0] always 0)
HART_ID, 32'd0, value returned by mhartid
MISA_VAL, 32'h4000_1100, read-only misa value (RV32IM)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
csr_valid  in  1  CSR instruction valid this cycle (decoder is_csr qualified by pipeline valid/no-flush)
csr_op_type  in  2  00=RW, 01=RS, 10=RC, 11=reserved
csr_use_imm  in  1  source is zimm rather than rs1_data
csr_addr  in  12  CSR address
rs1_addr  in  5  rs1 field; doubles as zimm when csr_use_imm=1
rs1_data  in  32  rs1 register value
csr_rdata  out  32  old CSR value, written to rd
csr_illegal  out  1  access is illegal; no state change
instret_inc  in  1  one instruction retired this cycle
trap_valid  in  1  take trap this cycle
trap_cause  in  32  mcause value
trap_pc  in  32  faulting PC
trap_tval  in  32  mtval value
mret_valid  in  1  MRET retiring this cycle
trap_vector  out  32  current mtvec
mepc_out  out  32  current mepc
mie_global  out  1  mstatus.MIE

Behaviour:
Implemented CSRs:
- mstatus 0x300: only MIE[3], MPIE[7] and MPP[12:11] are stored. MPP is hardwired to 2'b11. All other bits read 0.
- misa 0x301; mie 0x304; mtvec 0x305; mscratch 0x340; mepc 0x341; mcause 0x342; mtval 0x343.
- mip 0x344: reads 0; writes are ignored.
- mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82.
- cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82: read-only mirrors of the machine counters.
- mhartid 0xF14.

Reset (rst=1 at a clock edge):
- mstatus = 32'h0000_1800.
- mtvec = MTVEC_RESET.
- All other stored CSRs and both 64-bit counters = 0.
- Outputs follow: trap_vector = MTVEC_RESET, mepc_out = 0, mie_global = 0.
- Reset overrides every other input in the same cycle.

Read path:
- csr_rdata is combinational from csr_addr and reflects the pre-update value.
- csr_rdata is 0 when csr_valid=0 or the access is illegal.

Source and write value:
- Source is {27'b0, rs1_addr} when csr_use_imm=1, else rs1_data.
- RW: new = src. RS: new = old | src. RC: new = old & ~src.

Write intent:
- RW always writes.
- RS/RC write only if rs1_addr != 0. This suppresses the write for both the register and zimm forms.

csr_illegal=1 when csr_valid and any of:
- unimplemented address;
- csr_op_type=11;
- write intent to an address with csr_addr[11:10]=2'b11 (read-only), which also covers misa, mhartid and the user counters.

Write side effects:
- The update lands at the next clock edge.
- Masks on write: mtvec bits[1:0] forced 0; mepc bits[1:0] forced 0; mstatus keeps only bits 3 and 7 writable.

Counters:
- mcycle increments by 1 every non-reset cycle, with 64-bit carry from the low word into mcycleh.
- minstret increments when instret_inc=1.
- A CSR write to either half in the same cycle wins for the whole counter: the written half takes the new value, the other half holds, and there is no increment that cycle.
- Both counters wrap from all-ones to 0.

Trap entry (trap_valid=1):
- mepc <= {trap_pc[31:2], 2'b00}.
- mcause <= trap_cause; mtval <= trap_tval.
- MPIE <= MIE; MIE <= 0.

MRET (mret_valid=1):
- MIE <= MPIE; MPIE <= 1; MPP stays 11.

Same-cycle priority for non-counter state: rst > trap_valid > mret_valid > CSR write.
- The losing CSR write is dropped entirely; csr_rdata is still driven.
- Counters are independent of trap/mret.

Outputs:
- trap_vector, mepc_out and mie_global are registered state with zero-cycle output delay.
- A trap taken at edge N shows the new mepc_out from cycle N+1.

Test Plan:
- Reset, then read 0x300/0x305/0xF14/0x301 -> rdata 0x00001800, MTVEC_RESET, 0, 0x40001100.
- CSRRW mscratch, rs1_data=0xDEADBEEF, then CSRRS mscratch with rs1_addr=0 -> second rdata 0xDEADBEEF, value unchanged; then CSRRCI zimm=0x0F -> mscratch 0xDEADBEE0.
- Write mtvec 0x80000007 -> reads back 0x80000004; CSRRW to 0xC00 -> csr_illegal=1, cycle count unaffected; read 0x7C0 -> illegal, rdata 0.
- Set MIE=1 via CSRRSI 0x300 zimm=8; trap_valid with pc=0x100, cause=0x0B, tval=0 -> mepc=0x100, mcause=0xB, mstatus=0x1880; then mret -> mstatus=0x1888.
- Trap and CSRRW mepc=0x200 in the same cycle -> mepc=trap_pc and the write is dropped.
- CSRRW mcycle=0xFFFFFFFF, mcycleh=0 -> two cycles later mcycleh=1 and mcycle low=0x00000000 (carry); instret_inc pulsed 3 times -> minstret=3.
